// File: rtl/full_stage_ctrl_param_pkg.sv
// Shared definitions for the parametrised full-network stage controller.
// Provides the float_24_8 word width, the default first error-phase tap
// row, the update-sequencer state encoding and the tap-row width helper.
package full_stage_ctrl_param_pkg;

    localparam int unsigned FLOAT_24_8_W = 32;
    localparam int unsigned ERR_BASE_DEF = 12;

    typedef enum logic [1:0] {
        UPD_IDLE,
        UPD_UPDATE,
        UPD_FLUSH
    } upd_state_e;

    function automatic int unsigned tap_row_w(input int unsigned ntaps,
                                              input int unsigned data_w);
        return ntaps * data_w;
    endfunction

endpackage

// File: rtl/full_stage_ctrl_param_skid2.sv
// Two-entry skid buffer used on each stage output.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   push_i, data_i       write strobe and word
//   vld_o, data_o        head-of-queue valid and word
//   rdy_i                downstream ready; pop happens on vld_o & rdy_i
//   ovf_pulse_o          push arrived while full with no pop (word dropped)
module full_stage_skid2 #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rdy_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o,
    output logic              ovf_pulse_o
);

    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic [1:0]        cnt_q;
    logic              pop;
    logic              full;

    assign full        = (cnt_q == 2'd2);
    assign pop         = (cnt_q != 2'd0) & rdy_i;
    assign ovf_pulse_o = push_i & full & ~pop;
    assign vld_o       = (cnt_q != 2'd0);
    assign data_o      = head_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else if (pop) begin
            if (push_i) begin
                // Occupancy unchanged; new word lands behind whatever remains.
                if (full) begin
                    head_q <= tail_q;
                    tail_q <= data_i;
                end else begin
                    head_q <= data_i;
                end
            end else begin
                head_q <= tail_q;
                cnt_q  <= cnt_q - 2'd1;
            end
        end else if (push_i && !full) begin
            if (cnt_q == 2'd0) begin
                head_q <= data_i;
            end else begin
                tail_q <= data_i;
            end
            cnt_q <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/full_stage_ctrl_param.sv
// Per-stage output control for the full-network datapath: address and
// strobe generation for the data, tap and bias memories, delayed tap/bias
// write-back, an update sequencer with completion pulse, and skid-buffered
// data and error outputs with a sticky overflow flag.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   active*, first                    stage phase flags; first = active_start_d
//   data_*                            data memory interface (pass-through)
//   tap_*, error_*                    tap memory read/write-back/sub-word control
//   bias_*                            bias memory interface
//   st_*                              arithmetic results to store or emit
//   data_out*, err_out*               skid-buffered stage outputs
//   update_done, ovf                  update-complete pulse, sticky overflow
module full_stage_ctrl_param
    import full_stage_ctrl_param_pkg::*;
#(
    parameter int unsigned DATA_W   = FLOAT_24_8_W,
    parameter int unsigned NTAPS    = 6,
    parameter int unsigned DATA_AW  = 6,
    parameter int unsigned TAP_AW   = 4,
    parameter int unsigned ERR_BASE = ERR_BASE_DEF,
    parameter int unsigned NPHASE_W = 2,
    parameter int unsigned WB_LAT   = 5,
    parameter int unsigned BIAS_LAT = 4,
    parameter int unsigned ERR_LAT  = 10
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                active,
    input  logic                                active_pre,
    input  logic                                active_normal,
    input  logic                                active_start_d,
    input  logic                                data_valid,
    input  logic [DATA_AW-1:0]                  data_write_addr,
    input  logic [DATA_AW-1:0]                  data_read_addr,
    input  logic [DATA_W-1:0]                   data_value,
    input  logic [TAP_AW-1:0]                   tap_address,
    input  logic                                tap_enable,
    input  logic                                bias_enable,
    input  logic [TAP_AW-1:0]                   bias_wr_address,
    input  logic                                error_update_first,
    input  logic                                error_update_latch,
    input  logic                                error_tap_update_out,
    input  logic [NPHASE_W-1:0]                 error_phase,
    input  logic [NPHASE_W-1:0]                 error_phase_read,
    input  logic                                error_valid,
    input  logic [DATA_W-1:0]                   error_sub_address,
    input  logic [DATA_W-1:0]                   error_value,
    input  logic [DATA_W-1:0]                   st_data_out,
    input  logic [DATA_W-1:0]                   st_data_out_pre,
    input  logic [DATA_W-1:0]                   st_data_out_bias,
    input  logic [tap_row_w(NTAPS, DATA_W)-1:0] st_tap_out,
    input  logic                                data_out_rdy,
    input  logic                                err_out_rdy,
    output logic                                data_rd_vld,
    output logic                                data_wr_vld,
    output logic [DATA_AW-1:0]                  data_rd_addr,
    output logic [DATA_AW-1:0]                  data_wr_addr,
    output logic [DATA_W-1:0]                   data_wr_data,
    output logic                                tap_rd_vld,
    output logic                                tap_wr_vld,
    output logic                                tap_sub_vld,
    output logic                                tap_inter,
    output logic                                tap_inter_first,
    output logic [TAP_AW-1:0]                   tap_rd_addr,
    output logic [TAP_AW-1:0]                   tap_wr_addr,
    output logic [DATA_W-1:0]                   tap_sub_addr,
    output logic [DATA_W-1:0]                   tap_sub_data,
    output logic [tap_row_w(NTAPS, DATA_W)-1:0] tap_wr_data,
    output logic                                bias_rd_vld,
    output logic                                bias_wr_vld,
    output logic [TAP_AW-1:0]                   bias_rd_addr,
    output logic [TAP_AW-1:0]                   bias_wr_addr,
    output logic [DATA_W-1:0]                   bias_wr_data,
    output logic [DATA_W-1:0]                   data_out,
    output logic [DATA_W-1:0]                   err_out,
    output logic                                data_out_vld,
    output logic                                err_out_vld,
    output logic                                first,
    output logic                                update_done,
    output logic                                ovf
);

    localparam int unsigned CNT_W     = $clog2(WB_LAT + 1);
    localparam int unsigned START_LAT = 2;

    logic              wb_vld;
    logic              wb_vld_d;
    logic [TAP_AW-1:0] wb_addr_d;
    logic              upd_d;
    logic              bias_vld_d;
    logic              err_emit_d;
    logic              start_d2;
    logic [TAP_AW-1:0] err_wr_addr;
    logic              data_ovf;
    logic              err_ovf;
    logic              ovf_q;
    upd_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;

    // active_pre carries no function in this generation of the stage.
    logic unused_inputs;
    assign unused_inputs = active_pre;

    // Data memory
    assign data_wr_vld  = data_valid;
    assign data_rd_vld  = active_normal;
    assign data_wr_addr = data_write_addr;
    assign data_rd_addr = data_read_addr;
    assign data_wr_data = data_value;

    // Tap memory
    assign tap_rd_addr = error_update_first
                       ? TAP_AW'(ERR_BASE) + TAP_AW'(error_phase_read)
                       : tap_address;
    assign tap_rd_vld      = active_normal;
    assign err_wr_addr     = TAP_AW'(ERR_BASE) + TAP_AW'(error_phase);
    assign wb_vld          = error_update_latch & ~error_update_first;
    assign tap_wr_addr     = wb_vld_d ? wb_addr_d : err_wr_addr;
    assign tap_wr_vld      = error_valid | (tap_enable & wb_vld_d & ~upd_d);
    assign tap_sub_vld     = wb_vld_d ? 1'b0 : error_valid;
    assign tap_sub_addr    = error_sub_address;
    assign tap_sub_data    = error_value;
    assign tap_wr_data     = st_tap_out;
    assign tap_inter       = error_tap_update_out;
    assign tap_inter_first = error_update_first;

    // Bias memory
    assign bias_rd_addr = tap_address;
    assign bias_rd_vld  = tap_rd_vld;
    assign bias_wr_vld  = bias_enable & bias_vld_d;
    assign bias_wr_addr = bias_wr_address;
    assign bias_wr_data = st_data_out_bias;

    assign first       = active_start_d;
    assign update_done = done_q;
    assign ovf         = ovf_q;

    // Write-back pipe: valid, read address and update-out flag travel together.
    for (genvar g = 0; g < WB_LAT; g++) begin : g_wb
        logic              vld_q, upd_q, vld_in, upd_in;
        logic [TAP_AW-1:0] addr_q, addr_in;
        if (g == 0) begin : g_src
            assign vld_in  = wb_vld;
            assign upd_in  = error_tap_update_out;
            assign addr_in = tap_rd_addr;
        end else begin : g_src
            assign vld_in  = g_wb[g-1].vld_q;
            assign upd_in  = g_wb[g-1].upd_q;
            assign addr_in = g_wb[g-1].addr_q;
        end
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_q  <= 1'b0;
                upd_q  <= 1'b0;
                addr_q <= '0;
            end else begin
                vld_q  <= vld_in;
                upd_q  <= upd_in;
                addr_q <= addr_in;
            end
        end
    end
    assign wb_vld_d   = g_wb[WB_LAT-1].vld_q;
    assign upd_d      = g_wb[WB_LAT-1].upd_q;
    assign wb_addr_d  = g_wb[WB_LAT-1].addr_q;
    assign bias_vld_d = g_wb[BIAS_LAT-1].vld_q;

    for (genvar g = 0; g < ERR_LAT; g++) begin : g_err
        logic q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)    q <= 1'b0;
            else if (g == 0) q <= error_tap_update_out;
            else             q <= g_err[(g == 0) ? 0 : g-1].q;
        end
    end
    assign err_emit_d = g_err[ERR_LAT-1].q;

    for (genvar g = 0; g < START_LAT; g++) begin : g_start
        logic q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)    q <= 1'b0;
            else if (g == 0) q <= active_start_d;
            else             q <= g_start[(g == 0) ? 0 : g-1].q;
        end
    end
    assign start_d2 = g_start[START_LAT-1].q;

    // Update sequencer. The cycle that sees the latch fall already counts as
    // the first flush cycle, so the FSM spends WB_LAT-1 cycles in FLUSH and
    // done_q is armed one cycle early to land on the last write-back cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= UPD_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                UPD_IDLE: begin
                    if (wb_vld) state_q <= UPD_UPDATE;
                end
                UPD_UPDATE: begin
                    if (!error_update_latch) begin
                        if (WB_LAT == 1) begin
                            state_q <= UPD_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= UPD_FLUSH;
                            cnt_q   <= CNT_W'(WB_LAT - 1);
                            done_q  <= (WB_LAT == 2);
                        end
                    end
                end
                UPD_FLUSH: begin
                    if (wb_vld) begin
                        state_q <= UPD_UPDATE;
                    end else begin
                        cnt_q  <= cnt_q - 1'b1;
                        done_q <= (cnt_q == CNT_W'(2));
                        if (cnt_q == CNT_W'(1)) state_q <= UPD_IDLE;
                    end
                end
                default: state_q <= UPD_IDLE;
            endcase
        end
    end

    full_stage_skid2 #(.DATA_W(DATA_W)) u_data_skid (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .push_i      (active),
        .data_i      (st_data_out),
        .rdy_i       (data_out_rdy),
        .vld_o       (data_out_vld),
        .data_o      (data_out),
        .ovf_pulse_o (data_ovf)
    );

    full_stage_skid2 #(.DATA_W(DATA_W)) u_err_skid (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .push_i      (err_emit_d & ~start_d2),
        .data_i      (st_data_out_pre),
        .rdy_i       (err_out_rdy),
        .vld_o       (err_out_vld),
        .data_o      (err_out),
        .ovf_pulse_o (err_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ovf_q <= 1'b0;
        else          ovf_q <= ovf_q | data_ovf | err_ovf;
    end

endmodule

// File: tb/tb_full_stage_ctrl_param.sv
// Directed self-checking bench for full_stage_ctrl_param.
// Cycle c: inputs are applied shortly after posedge c and outputs are
// sampled before posedge c+1.
module tb_full_stage_ctrl_param;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NTAPS    = 6;
    localparam int unsigned DATA_AW  = 6;
    localparam int unsigned TAP_AW   = 4;
    localparam int unsigned ERR_BASE = 12;
    localparam int unsigned NPHASE_W = 2;
    localparam int unsigned WB_LAT   = 5;
    localparam int unsigned BIAS_LAT = 4;
    localparam int unsigned ERR_LAT  = 10;
    localparam int unsigned TAP_W    = NTAPS * DATA_W;

    logic clk, reset_n;
    logic active, active_pre, active_normal, active_start_d, data_valid;
    logic [DATA_AW-1:0] data_write_addr, data_read_addr;
    logic [DATA_W-1:0]  data_value;
    logic [TAP_AW-1:0]  tap_address, bias_wr_address;
    logic tap_enable, bias_enable;
    logic error_update_first, error_update_latch, error_tap_update_out, error_valid;
    logic [NPHASE_W-1:0] error_phase, error_phase_read;
    logic [DATA_W-1:0]  error_sub_address, error_value;
    logic [DATA_W-1:0]  st_data_out, st_data_out_pre, st_data_out_bias;
    logic [TAP_W-1:0]   st_tap_out;
    logic data_out_rdy, err_out_rdy;
    logic data_rd_vld, data_wr_vld;
    logic [DATA_AW-1:0] data_rd_addr, data_wr_addr;
    logic [DATA_W-1:0]  data_wr_data;
    logic tap_rd_vld, tap_wr_vld, tap_sub_vld, tap_inter, tap_inter_first;
    logic [TAP_AW-1:0]  tap_rd_addr, tap_wr_addr;
    logic [DATA_W-1:0]  tap_sub_addr, tap_sub_data;
    logic [TAP_W-1:0]   tap_wr_data;
    logic bias_rd_vld, bias_wr_vld;
    logic [TAP_AW-1:0]  bias_rd_addr, bias_wr_addr;
    logic [DATA_W-1:0]  bias_wr_data, data_out, err_out;
    logic data_out_vld, err_out_vld, first, update_done, ovf;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    full_stage_ctrl_param #(
        .DATA_W(DATA_W), .NTAPS(NTAPS), .DATA_AW(DATA_AW), .TAP_AW(TAP_AW),
        .ERR_BASE(ERR_BASE), .NPHASE_W(NPHASE_W), .WB_LAT(WB_LAT),
        .BIAS_LAT(BIAS_LAT), .ERR_LAT(ERR_LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .active(active), .active_pre(active_pre), .active_normal(active_normal),
        .active_start_d(active_start_d), .data_valid(data_valid),
        .data_write_addr(data_write_addr), .data_read_addr(data_read_addr),
        .data_value(data_value), .tap_address(tap_address),
        .tap_enable(tap_enable), .bias_enable(bias_enable),
        .bias_wr_address(bias_wr_address),
        .error_update_first(error_update_first),
        .error_update_latch(error_update_latch),
        .error_tap_update_out(error_tap_update_out),
        .error_phase(error_phase), .error_phase_read(error_phase_read),
        .error_valid(error_valid), .error_sub_address(error_sub_address),
        .error_value(error_value), .st_data_out(st_data_out),
        .st_data_out_pre(st_data_out_pre), .st_data_out_bias(st_data_out_bias),
        .st_tap_out(st_tap_out), .data_out_rdy(data_out_rdy),
        .err_out_rdy(err_out_rdy),
        .data_rd_vld(data_rd_vld), .data_wr_vld(data_wr_vld),
        .data_rd_addr(data_rd_addr), .data_wr_addr(data_wr_addr),
        .data_wr_data(data_wr_data), .tap_rd_vld(tap_rd_vld),
        .tap_wr_vld(tap_wr_vld), .tap_sub_vld(tap_sub_vld),
        .tap_inter(tap_inter), .tap_inter_first(tap_inter_first),
        .tap_rd_addr(tap_rd_addr), .tap_wr_addr(tap_wr_addr),
        .tap_sub_addr(tap_sub_addr), .tap_sub_data(tap_sub_data),
        .tap_wr_data(tap_wr_data), .bias_rd_vld(bias_rd_vld),
        .bias_wr_vld(bias_wr_vld), .bias_rd_addr(bias_rd_addr),
        .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
        .data_out(data_out), .err_out(err_out),
        .data_out_vld(data_out_vld), .err_out_vld(err_out_vld),
        .first(first), .update_done(update_done), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        active = 0; active_pre = 0; active_normal = 0; active_start_d = 0;
        data_valid = 0; data_write_addr = '0; data_read_addr = '0; data_value = '0;
        tap_address = '0; tap_enable = 0; bias_enable = 0; bias_wr_address = '0;
        error_update_first = 0; error_update_latch = 0; error_tap_update_out = 0;
        error_phase = '0; error_phase_read = '0; error_valid = 0;
        error_sub_address = '0; error_value = '0;
        st_data_out = '0; st_data_out_pre = '0; st_data_out_bias = '0; st_tap_out = '0;
        data_out_rdy = 0; err_out_rdy = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_data_out_vld", data_out_vld, 1'b0);
        check_eq("rst_err_out_vld", err_out_vld, 1'b0);
        check_eq("rst_ovf", ovf, 1'b0);
        check_eq("rst_update_done", update_done, 1'b0);
        check_eq("rst_tap_wr_vld", tap_wr_vld, 1'b0);
        check_eq("rst_bias_wr_vld", bias_wr_vld, 1'b0);
        reset_n = 1'b1;
        next_cycle();

        // Combinational paths
        data_valid = 1; data_write_addr = 6'd5; data_value = 32'hDEAD_BEEF;
        active_normal = 1; data_read_addr = 6'd33;
        settle();
        check_eq("data_wr_vld", data_wr_vld, 1'b1);
        check_eq("data_wr_addr", data_wr_addr, 64'd5);
        check_eq("data_wr_data", data_wr_data, 64'hDEAD_BEEF);
        check_eq("data_rd_vld", data_rd_vld, 1'b1);
        check_eq("data_rd_addr", data_rd_addr, 64'd33);
        check_eq("bias_rd_vld", bias_rd_vld, 1'b1);
        error_update_first = 1; error_phase_read = 2'd2; tap_address = 4'd3;
        settle();
        check_eq("tap_rd_addr_err", tap_rd_addr, 64'd14);
        check_eq("tap_inter_first", tap_inter_first, 1'b1);
        error_update_first = 0;
        settle();
        check_eq("tap_rd_addr_norm", tap_rd_addr, 64'd3);
        check_eq("bias_rd_addr", bias_rd_addr, 64'd3);
        error_valid = 1; error_phase = 2'd1; error_sub_address = 32'd7; error_value = 32'h55;
        settle();
        check_eq("sub_tap_wr_vld", tap_wr_vld, 1'b1);
        check_eq("sub_tap_sub_vld", tap_sub_vld, 1'b1);
        check_eq("sub_tap_wr_addr", tap_wr_addr, 64'd13);
        check_eq("sub_tap_sub_addr", tap_sub_addr, 64'd7);
        check_eq("sub_tap_sub_data", tap_sub_data, 64'h55);
        clear_inputs();
        next_cycle();

        // Write-back and bias latency; error sub-write collides on cycle 5
        tap_enable = 1; bias_enable = 1; bias_wr_address = 4'd9;
        st_data_out_bias = 32'h1234;
        st_tap_out = '0;
        st_tap_out[63:0] = 64'hCAFE_0001_BEEF_0002;
        error_phase = 2'd1;
        for (int c = 0; c <= 7; c++) begin
            error_update_latch = (c == 0);
            tap_address = (c == 0) ? 4'd7 : 4'd2;
            error_valid = (c == 5);
            settle();
            check_eq($sformatf("wb_tap_wr_vld_c%0d", c), tap_wr_vld, (c == 5));
            check_eq($sformatf("wb_bias_wr_vld_c%0d", c), bias_wr_vld, (c == 4));
            if (c == 5) begin
                check_eq("wb_tap_wr_addr", tap_wr_addr, 64'd7);
                check_eq("wb_tap_sub_vld", tap_sub_vld, 1'b0);
                check_eq("wb_tap_wr_data", tap_wr_data[63:0], 64'hCAFE_0001_BEEF_0002);
            end
            if (c == 4) begin
                check_eq("wb_bias_wr_addr", bias_wr_addr, 64'd9);
                check_eq("wb_bias_wr_data", bias_wr_data, 64'h1234);
            end
            next_cycle();
        end
        clear_inputs();
        repeat (10) next_cycle();

        // Update FSM: plain flush
        for (int c = 0; c <= 10; c++) begin
            error_update_latch = (c <= 2);
            settle();
            check_eq($sformatf("upd_done_a_c%0d", c), update_done, (c == 7));
            next_cycle();
        end
        repeat (4) next_cycle();

        // Update FSM: latch re-asserted mid-flush
        for (int c = 0; c <= 12; c++) begin
            error_update_latch = (c <= 2) || (c == 4);
            settle();
            check_eq($sformatf("upd_done_b_c%0d", c), update_done, (c == 9));
            next_cycle();
        end
        clear_inputs();
        repeat (4) next_cycle();

        // Data output backpressure and overflow
        for (int c = 0; c <= 2; c++) begin
            active = 1; st_data_out = 32'(c + 1); data_out_rdy = 0;
            settle();
            if (c > 0) begin
                check_eq($sformatf("bp_hold_c%0d", c), data_out, 64'd1);
                check_eq($sformatf("bp_vld_c%0d", c), data_out_vld, 1'b1);
            end
            next_cycle();
        end
        active = 0;
        settle();
        check_eq("bp_head", data_out, 64'd1);
        check_eq("bp_ovf", ovf, 1'b1);
        data_out_rdy = 1;
        settle();
        check_eq("bp_pop1", data_out, 64'd1);
        next_cycle();
        check_eq("bp_pop2", data_out, 64'd2);
        check_eq("bp_pop2_vld", data_out_vld, 1'b1);
        next_cycle();
        check_eq("bp_empty", data_out_vld, 1'b0);
        data_out_rdy = 0;
        repeat (2) next_cycle();

        // Error emit delay
        st_data_out_pre = 32'hAB;
        for (int c = 0; c <= 12; c++) begin
            error_tap_update_out = (c == 0);
            settle();
            check_eq($sformatf("emit_vld_c%0d", c), err_out_vld, (c >= 11));
            if (c == 11) check_eq("emit_data", err_out, 64'hAB);
            next_cycle();
        end
        err_out_rdy = 1;
        next_cycle();
        check_eq("emit_popped", err_out_vld, 1'b0);
        err_out_rdy = 0;

        // Error emit suppressed by active_start_d
        for (int c = 0; c <= 13; c++) begin
            error_tap_update_out = (c == 0);
            active_start_d = (c == 8);
            settle();
            if (c == 8) check_eq("first_flag", first, 1'b1);
            check_eq($sformatf("suppr_vld_c%0d", c), err_out_vld, 1'b0);
            next_cycle();
        end
        clear_inputs();
        repeat (2) next_cycle();

        // Asynchronous reset mid-flush with a full data FIFO
        st_data_out = 32'h77;
        for (int c = 0; c <= 5; c++) begin
            error_update_latch = (c == 0);
            active = (c <= 1);
            settle();
            if (c < 5) next_cycle();
        end
        check_eq("pre_rst_done", update_done, 1'b1);
        check_eq("pre_rst_vld", data_out_vld, 1'b1);
        check_eq("pre_rst_ovf", ovf, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("arst_data_vld", data_out_vld, 1'b0);
        check_eq("arst_err_vld", err_out_vld, 1'b0);
        check_eq("arst_ovf", ovf, 1'b0);
        check_eq("arst_done", update_done, 1'b0);
        clear_inputs();
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
        check_eq("post_rst_vld", data_out_vld, 1'b0);
        for (int c = 0; c <= 7; c++) begin
            error_update_latch = (c == 0);
            settle();
            check_eq($sformatf("restart_done_c%0d", c), update_done, (c == 5));
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/full_stage_ctrl_param.md
Name: full_stage_ctrl_param

Overview:
Parametrised successor of the per-stage output-control block in the full-network datapath. It generates address and control for the stage's data, tap and bias memories. Tap write-back and error-emit delays are set by parameters instead of fixed shift depths. New relative to the previous generation:
- an update-sequencer FSM with completion pulse;
- valid/ready skid buffering on both stage outputs, which honours downstream rdy instead of ignoring it.

Parameters:
DATA_W, 32, float word width (float_24_8 = 32)
NTAPS, 6, taps per memory row; tap row width = NTAPS*DATA_W
DATA_AW, 6, data memory address width
TAP_AW, 4, tap/bias memory address width
ERR_BASE, 12, first tap row reserved for error-phase rows
NPHASE_W, 2, error-phase index width; ERR_BASE + 2^NPHASE_W <= 2^TAP_AW
WB_LAT, 5, tap write-back pipeline latency (cycles, >=1)
BIAS_LAT, 4, bias write latency (<= WB_LAT)
ERR_LAT, 10, error-output emit delay after error_tap_update_out (>= 3)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
active, active_pre, active_normal, active_start_d  in  1  stage phase flags
data_valid  in  1  data memory write strobe
data_write_addr, data_read_addr  in  DATA_AW  data memory addresses
data_value  in  DATA_W  data memory write data
tap_address  in  TAP_AW  normal tap/bias read address
tap_enable, bias_enable  in  1  enable tap/bias write-back
bias_wr_address  in  TAP_AW  bias write address
error_update_first, error_update_latch, error_tap_update_out  in  1  update control
error_phase, error_phase_read  in  NPHASE_W  error row select (write/read)
error_valid  in  1  error sub-word write strobe
error_sub_address  in  DATA_W  sub-word select
error_value  in  DATA_W  sub-word data
st_data_out, st_data_out_pre, st_data_out_bias  in  DATA_W  arithmetic results
st_tap_out  in  NTAPS*DATA_W  updated tap row
data_out_rdy, err_out_rdy  in  1  downstream ready
data_rd_vld, data_wr_vld  out  1  data memory strobes
data_rd_addr, data_wr_addr  out  DATA_AW  data memory addresses
data_wr_data  out  DATA_W  data memory write data
tap_rd_vld, tap_wr_vld, tap_sub_vld, tap_inter, tap_inter_first  out  1  tap memory control
tap_rd_addr, tap_wr_addr  out  TAP_AW  tap memory addresses
tap_sub_addr, tap_sub_data  out  DATA_W  sub-word write fields
tap_wr_data  out  NTAPS*DATA_W  tap write data
bias_rd_vld, bias_wr_vld  out  1  bias memory strobes
bias_rd_addr, bias_wr_addr  out  TAP_AW  bias memory addresses
bias_wr_data  out  DATA_W  bias write data
data_out, err_out  out  DATA_W  stage outputs
data_out_vld, err_out_vld  out  1  output valids
first  out  1  = active_start_d
update_done  out  1  one-cycle update-complete pulse
ovf  out  1  sticky overflow flag

Behaviour:
- Reset: all registered outputs, shift pipes, FIFOs, FSM and ovf clear to 0 asynchronously. Combinational outputs follow their inputs.
- Data memory (combinational):
  - wr_vld = data_valid; rd_vld = active_normal.
  - Addresses and write data pass through.
- Tap read (combinational):
  - tap_rd_addr = error_update_first ? ERR_BASE + error_phase_read : tap_address.
  - tap_rd_vld = active_normal.
- Write-back pipeline:
  - wb_vld = error_update_latch & ~error_update_first.
  - wb_vld and tap_rd_addr are delayed WB_LAT cycles (wb_vld_d, wb_addr_d).
  - tap_wr_addr = wb_vld_d ? wb_addr_d : ERR_BASE + error_phase.
  - Let upd_d = error_tap_update_out delayed WB_LAT cycles.
  - tap_wr_vld = error_valid | (tap_enable & wb_vld_d & ~upd_d).
  - tap_sub_vld = wb_vld_d ? 0 : error_valid; write-back wins on collision.
  - tap_wr_data = st_tap_out.
  - tap_inter = error_tap_update_out; tap_inter_first = error_update_first.
- Bias memory:
  - rd_addr = tap_address; rd_vld = tap_rd_vld.
  - wr_vld = bias_enable & wb_vld delayed BIAS_LAT cycles.
  - wr_addr = bias_wr_address; wr_data = st_data_out_bias.
- Update FSM:
  - IDLE -> UPDATE on error_update_latch & ~error_update_first.
  - UPDATE -> FLUSH when latch falls; load cnt = WB_LAT.
  - FLUSH: decrement cnt each cycle. At cnt==1, go to IDLE and pulse update_done.
  - A latch re-assertion in FLUSH returns to UPDATE, cancels the pending pulse, and keeps the pipes intact.
- Data output:
  - Push st_data_out when active.
  - 2-entry skid FIFO; head shown on data_out/data_out_vld; pop on vld & rdy.
  - Simultaneous push and pop when full is accepted.
  - Push when full with no pop is dropped and sets ovf.
- Error output:
  - Push st_data_out_pre when error_tap_update_out delayed ERR_LAT cycles is high and active_start_d delayed 2 cycles is low.
  - Same 2-entry skid FIFO and overflow rule as the data output.
- Outputs hold while vld & ~rdy.
- ovf clears only on reset.

Decomposition:
- Shared package: float_24_8 width constant, ERR_BASE default, tap-row width function NTAPS*DATA_W.
- Sub-module full_stage_skid2 (DATA_W param; push/data, vld/rdy, ovf_pulse), instanced twice.
- Delay pipes are a generate loop with no separate module.

Test Plan:
- Tap read mux: error_update_first=1, error_phase_read=2 -> tap_rd_addr=14. Drop error_update_first with tap_address=3 -> tap_rd_addr=3.
- Write-back (WB_LAT=5): latch pulse on cycle 0 with tap_address=7, tap_enable=1 -> tap_wr_vld=1, tap_wr_addr=7, tap_sub_vld=0 on cycle 5. bias_wr_vld=1 on cycle 4.
- Update FSM: latch high cycles 0-2 -> update_done pulses once on cycle 7 (state UPDATE through cycle 2, FLUSH cycles 3-7). Latch re-asserted on cycle 4 -> no pulse until the new flush completes.
- Output backpressure: active for 3 cycles with data_out_rdy=0, values 1,2,3 -> data_out holds 1, ovf=1. Set rdy=1 -> outputs 1 then 2.
- Error emit: error_tap_update_out pulse on cycle 0, active_start_d=0 -> err_out_vld on cycle ERR_LAT+1. With active_start_d=1 on cycle ERR_LAT-2 -> no push.
- Async reset: assert reset_n=0 mid-flush with a full FIFO -> all vld, ovf and update_done go 0 immediately without a clock edge. FSM restarts in IDLE.
